vga_pixel_scanner: RTL and testbench

Generates the VGA raster: pixel-clock tick, scan coordinates `pixelX`/`pixelY` for every object module, and hsync/vsync/blank for the DAC. Sync and blank are delayed by a fixed number of clocks so they line up with the registered RGB from the objects and the objects mux. Sits at the top of the video pipeline; every drawing module consumes its coordinates.

---
 rtl/vga_pixel_scanner_pkg.sv | 40 ++++
 rtl/vga_pixel_scanner_if.sv | 22 ++
 rtl/vga_pixel_scanner_sync_delay_line.sv | 34 +++
 rtl/vga_pixel_scanner.sv | 154 +++++++++++++++
 tb/tb_vga_pixel_scanner.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_pixel_scanner_pkg.sv
// Purpose: shared timing defaults, scan phase type and helpers for the VGA
//          raster generator and its consumers.
// Contents: default 640x480@60 timing constants, coordinate/frame widths,
//           scan_phase_t shared by the horizontal and vertical phase FSMs,
//           scan_total() and next_phase() helpers.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int CLK_DIV_DEF         = 2;
  localparam int SYNC_DELAY_DEF      = 2;
  localparam bit SYNC_ACTIVE_LOW_DEF = 1'b1;

  localparam int COORD_W   = 11;
  localparam int COORD_MAX = 1023;  // largest positive signed 11-bit value
  localparam int FRAME_W   = 16;

  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} scan_phase_t;

  function automatic int scan_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic scan_phase_t next_phase(scan_phase_t p);
    case (p)
      ACTIVE:  return FRONT;
      FRONT:   return SYNC;
      SYNC:    return BACK;
      default: return ACTIVE;
    endcase
  endfunction

endpackage

// File: rtl/vga_pixel_scanner_if.sv
// Purpose: raster bundle from the scanner to the drawing objects and the DAC.
// Signals: pixelTick, pixelX/pixelY (signed 11), visible, startOfFrame,
//          frameCount (16), hsync/vsync/blankN (delayed to match RGB).
// Modports: master drives (scanner), slave observes (objects, DAC).
interface vga_pixel_scanner_if;
  import vga_pkg::*;

  logic                      pixelTick;
  logic signed [COORD_W-1:0] pixelX;
  logic signed [COORD_W-1:0] pixelY;
  logic                      visible;
  logic                      startOfFrame;
  logic [FRAME_W-1:0]        frameCount;
  logic                      hsync;
  logic                      vsync;
  logic                      blankN;

  modport master (output pixelTick, pixelX, pixelY, visible, startOfFrame,
                         frameCount, hsync, vsync, blankN);
  modport slave  (input  pixelTick, pixelX, pixelY, visible, startOfFrame,
                         frameCount, hsync, vsync, blankN);
endinterface

// File: rtl/vga_pixel_scanner_sync_delay_line.sv
// Purpose: async-reset shift register of DEPTH stages; DEPTH=0 is a wire.
// Ports: clk, resetN (async, active-low), i_data[WIDTH], o_data[WIDTH].
module sync_delay_line #(
  parameter int               WIDTH       = 1,
  parameter int               DEPTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  if (DEPTH == 0) begin : g_direct
    assign o_data = i_data;
    // clock and reset have no job in the zero-delay build
    logic w_unused;
    assign w_unused = clk | resetN;
  end else begin : g_shift
    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        for (int i = 0; i < DEPTH; i++) r_stage[i] <= RESET_VALUE;
      end else begin
        r_stage[0] <= i_data;
        for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
    end

    assign o_data = r_stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_pixel_scanner.sv
// Purpose: VGA raster generator. Produces the pixel tick, scan coordinates
//          for the drawing objects, frame bookkeeping and hsync/vsync/blankN
//          delayed to line up with the registered RGB path.
// Ports: clk, resetN (async, active-low), o_vga (vga_pixel_scanner_if.master).
//
// Phase FSMs (one horizontal, one vertical, same encoding):
//   state  | meaning
//   ACTIVE | visible pixels / lines
//   FRONT  | front porch
//   SYNC   | sync pulse
//   BACK   | back porch, ends at the wrap to 0
module vga_pixel_scanner
  import vga_pkg::*;
#(
  parameter int H_ACTIVE        = H_ACTIVE_DEF,
  parameter int H_FP            = H_FP_DEF,
  parameter int H_SYNC          = H_SYNC_DEF,
  parameter int H_BP            = H_BP_DEF,
  parameter int V_ACTIVE        = V_ACTIVE_DEF,
  parameter int V_FP            = V_FP_DEF,
  parameter int V_SYNC          = V_SYNC_DEF,
  parameter int V_BP            = V_BP_DEF,
  parameter int CLK_DIV         = CLK_DIV_DEF,
  parameter int SYNC_DELAY      = SYNC_DELAY_DEF,
  parameter bit SYNC_ACTIVE_LOW = SYNC_ACTIVE_LOW_DEF
) (
  input  logic                 clk,
  input  logic                 resetN,
  vga_pixel_scanner_if.master  o_vga
);

  localparam int H_TOTAL = scan_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = scan_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_bad_total
    $error("vga_pixel_scanner: H_TOTAL/V_TOTAL exceed signed 11-bit range");
  end
  if (CLK_DIV < 1 || SYNC_DELAY < 0) begin : g_bad_div
    $error("vga_pixel_scanner: CLK_DIV must be >= 1 and SYNC_DELAY >= 0");
  end

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  // last count of each phase; the BACK end is also the wrap point
  localparam logic [COORD_W-1:0] H_E0 = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] H_E1 = COORD_W'(H_ACTIVE + H_FP - 1);
  localparam logic [COORD_W-1:0] H_E2 = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] H_E3 = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_E0 = COORD_W'(V_ACTIVE - 1);
  localparam logic [COORD_W-1:0] V_E1 = COORD_W'(V_ACTIVE + V_FP - 1);
  localparam logic [COORD_W-1:0] V_E2 = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [COORD_W-1:0] V_E3 = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT_W = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT_W = COORD_W'(V_ACTIVE);

  function automatic logic at_bound(scan_phase_t p, logic [COORD_W-1:0] cnt,
                                    logic [COORD_W-1:0] e0, logic [COORD_W-1:0] e1,
                                    logic [COORD_W-1:0] e2, logic [COORD_W-1:0] e3);
    case (p)
      ACTIVE:  return cnt == e0;
      FRONT:   return cnt == e1;
      SYNC:    return cnt == e2;
      default: return cnt == e3;
    endcase
  endfunction

  logic [DIV_W-1:0]   r_div_cnt;
  logic               r_tick;
  logic [COORD_W-1:0] r_h_cnt;
  logic [COORD_W-1:0] r_v_cnt;
  scan_phase_t        r_h_phase;
  scan_phase_t        r_v_phase;
  logic               r_visible;
  logic               r_sof;
  logic [FRAME_W-1:0] r_frame_cnt;

  logic [DIV_W-1:0]   w_div_next;
  logic               w_line_end;
  logic               w_frame_end;
  logic               w_h_at_bound;
  logic               w_v_at_bound;
  logic [COORD_W-1:0] w_h_next;
  logic [COORD_W-1:0] w_v_next;

  assign w_div_next   = (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
  assign w_line_end   = (r_h_cnt == H_E3);
  assign w_frame_end  = (r_v_cnt == V_E3);
  assign w_h_at_bound = at_bound(r_h_phase, r_h_cnt, H_E0, H_E1, H_E2, H_E3);
  assign w_v_at_bound = at_bound(r_v_phase, r_v_cnt, V_E0, V_E1, V_E2, V_E3);
  assign w_h_next     = w_line_end ? '0 : r_h_cnt + 11'd1;
  assign w_v_next     = !w_line_end ? r_v_cnt :
                        (w_frame_end ? '0 : r_v_cnt + 11'd1);

  // The tick is registered from the next divider value so it is low in
  // reset and, with CLK_DIV=1, high on every clock after release.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_div_cnt   <= '0;
      r_tick      <= 1'b0;
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_h_phase   <= ACTIVE;
      r_v_phase   <= ACTIVE;
      r_visible   <= 1'b0;
      r_sof       <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_div_cnt <= w_div_next;
      r_tick    <= (w_div_next == DIV_LAST);
      r_sof     <= 1'b0;
      if (r_tick) begin
        r_h_cnt   <= w_h_next;
        r_v_cnt   <= w_v_next;
        r_visible <= (w_h_next < H_ACT_W) && (w_v_next < V_ACT_W);
        if (w_h_at_bound) r_h_phase <= next_phase(r_h_phase);
        if (w_line_end && w_v_at_bound) r_v_phase <= next_phase(r_v_phase);
        if (w_line_end && w_frame_end) begin
          r_sof       <= 1'b1;
          r_frame_cnt <= r_frame_cnt + 16'd1;
        end
      end
    end
  end

  // XOR with the polarity turns "in sync" into the pin level
  logic       w_hsync_raw;
  logic       w_vsync_raw;
  logic [2:0] w_delayed;

  assign w_hsync_raw = (r_h_phase == SYNC) ^ SYNC_ACTIVE_LOW;
  assign w_vsync_raw = (r_v_phase == SYNC) ^ SYNC_ACTIVE_LOW;

  sync_delay_line #(
    .WIDTH       (3),
    .DEPTH       (SYNC_DELAY),
    .RESET_VALUE ({SYNC_ACTIVE_LOW, SYNC_ACTIVE_LOW, 1'b0})
  ) u_sync_delay (
    .clk    (clk),
    .resetN (resetN),
    .i_data ({w_hsync_raw, w_vsync_raw, r_visible}),
    .o_data (w_delayed)
  );

  assign o_vga.pixelTick    = r_tick;
  assign o_vga.pixelX       = $signed(r_h_cnt);
  assign o_vga.pixelY       = $signed(r_v_cnt);
  assign o_vga.visible      = r_visible;
  assign o_vga.startOfFrame = r_sof;
  assign o_vga.frameCount   = r_frame_cnt;
  assign o_vga.hsync        = w_delayed[2];
  assign o_vga.vsync        = w_delayed[1];
  assign o_vga.blankN       = w_delayed[0];

endmodule

// File: tb/tb_vga_pixel_scanner.sv
// Bench for vga_pixel_scanner: three instances (default timing, a tiny raster
// for whole-frame behaviour, and CLK_DIV=1/no delay/active-high sync), each
// compared cycle by cycle against closed-form expectations of the raster.
module tb_vga_pixel_scanner;

  logic clk = 1'b0;
  logic resetN;
  logic resetN_b;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cur_cycle = 0;

  vga_pixel_scanner_if vga_a ();
  vga_pixel_scanner_if vga_b ();
  vga_pixel_scanner_if vga_c ();

  vga_pixel_scanner dut_a (.clk(clk), .resetN(resetN), .o_vga(vga_a));

  vga_pixel_scanner #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(2), .SYNC_DELAY(2), .SYNC_ACTIVE_LOW(1'b1)
  ) dut_b (.clk(clk), .resetN(resetN_b), .o_vga(vga_b));

  vga_pixel_scanner #(
    .CLK_DIV(1), .SYNC_DELAY(0), .SYNC_ACTIVE_LOW(1'b0)
  ) dut_c (.clk(clk), .resetN(resetN), .o_vga(vga_c));

  typedef struct {
    int d; int htot; int vtot; int hact; int vact;
    int hs_lo; int hs_hi; int vs_lo; int vs_hi; int dly; bit low;
  } cfg_t;

  cfg_t cfg_a = '{2, 800, 525, 640, 480, 656, 751, 490, 491, 2, 1'b1};
  cfg_t cfg_b = '{2, 16, 8, 8, 4, 10, 12, 5, 6, 2, 1'b1};
  cfg_t cfg_c = '{1, 800, 525, 640, 480, 656, 751, 490, 491, 0, 1'b0};

  // number of coordinate advances completed by the sample after clock m
  function automatic int ticks(int m, int d);
    if (m <= 0) return 0;
    return (d == 1) ? m - 1 : m / d;
  endfunction
  function automatic int xpos(int m, cfg_t c);
    return ticks(m, c.d) % c.htot;
  endfunction
  function automatic int ypos(int m, cfg_t c);
    return (ticks(m, c.d) / c.htot) % c.vtot;
  endfunction
  function automatic bit vis_at(int m, cfg_t c);
    return ticks(m, c.d) >= 1 && xpos(m, c) < c.hact && ypos(m, c) < c.vact;
  endfunction
  function automatic bit hs_on(int m, cfg_t c);
    if (m < 0) return 1'b0;
    return xpos(m, c) >= c.hs_lo && xpos(m, c) <= c.hs_hi;
  endfunction
  function automatic bit vs_on(int m, cfg_t c);
    if (m < 0) return 1'b0;
    return ypos(m, c) >= c.vs_lo && ypos(m, c) <= c.vs_hi;
  endfunction
  function automatic bit sof_at(int m, cfg_t c);
    int t;
    t = ticks(m, c.d);
    return t >= 1 && (t % (c.htot * c.vtot)) == 0 && t != ticks(m - 1, c.d);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cur_cycle, obs, exp);
    end
  endtask

  task automatic check_scan(input string p, input int n, input cfg_t c,
                            input logic tick, input logic [31:0] x, input logic [31:0] y,
                            input logic vis, input logic sof, input logic [31:0] fc,
                            input logic hs, input logic vs, input logic bn);
    cur_cycle = n;
    check({p, "_tick"}, 32'(tick), 32'(n >= 1 && (n % c.d) == c.d - 1));
    check({p, "_x"}, x, xpos(n, c));
    check({p, "_y"}, y, ypos(n, c));
    check({p, "_visible"}, 32'(vis), 32'(vis_at(n, c)));
    check({p, "_sof"}, 32'(sof), 32'(sof_at(n, c)));
    check({p, "_frames"}, fc, (ticks(n, c.d) / (c.htot * c.vtot)) % 65536);
    check({p, "_hsync"}, 32'(hs), 32'(hs_on(n - c.dly, c) ^ c.low));
    check({p, "_vsync"}, 32'(vs), 32'(vs_on(n - c.dly, c) ^ c.low));
    check({p, "_blankN"}, 32'(bn), 32'(vis_at(n - c.dly, c)));
  endtask

  // two-stage object+mux pipeline carried on pixelX of the default instance
  logic signed [10:0] pipe1, pipe2;
  always @(posedge clk) begin
    pipe1 <= vga_a.pixelX;
    pipe2 <= pipe1;
  end

  initial begin
    int hs_low_cnt;
    int align_cnt;
    logic prev_bn;
    bit found;

    resetN   = 1'b0;
    resetN_b = 1'b0;
    repeat (3) @(negedge clk);

    // reset values
    check("rst_a_tick", 32'(vga_a.pixelTick), 0);
    check("rst_a_x", vga_a.pixelX, 0);
    check("rst_a_y", vga_a.pixelY, 0);
    check("rst_a_visible", 32'(vga_a.visible), 0);
    check("rst_a_sof", 32'(vga_a.startOfFrame), 0);
    check("rst_a_frames", vga_a.frameCount, 0);
    check("rst_a_hsync", 32'(vga_a.hsync), 1);
    check("rst_a_vsync", 32'(vga_a.vsync), 1);
    check("rst_a_blankN", 32'(vga_a.blankN), 0);
    check("rst_c_tick", 32'(vga_c.pixelTick), 0);
    check("rst_c_hsync", 32'(vga_c.hsync), 0);
    check("rst_c_vsync", 32'(vga_c.vsync), 0);

    // release all instances together; this negedge is cycle 0
    resetN   = 1'b1;
    resetN_b = 1'b1;
    hs_low_cnt = 0;
    align_cnt  = 0;
    prev_bn    = 1'b0;
    for (int n = 1; n <= 1700; n++) begin
      @(negedge clk);
      check_scan("a", n, cfg_a, vga_a.pixelTick, vga_a.pixelX, vga_a.pixelY,
                 vga_a.visible, vga_a.startOfFrame, vga_a.frameCount,
                 vga_a.hsync, vga_a.vsync, vga_a.blankN);
      check_scan("c", n, cfg_c, vga_c.pixelTick, vga_c.pixelX, vga_c.pixelY,
                 vga_c.visible, vga_c.startOfFrame, vga_c.frameCount,
                 vga_c.hsync, vga_c.vsync, vga_c.blankN);
      if (n <= 600)
        check_scan("b", n, cfg_b, vga_b.pixelTick, vga_b.pixelX, vga_b.pixelY,
                   vga_b.visible, vga_b.startOfFrame, vga_b.frameCount,
                   vga_b.hsync, vga_b.vsync, vga_b.blankN);
      if (n >= 2 && n <= 1601 && !vga_a.hsync) hs_low_cnt++;
      if (n > 100 && vga_a.blankN && !prev_bn) begin
        align_cnt++;
        check("a_align_pixel0", pipe2, 0);
      end
      prev_bn = vga_a.blankN;
    end
    check("a_hsync_low_clocks_per_line", hs_low_cnt, 192);
    check("a_align_seen", align_cnt, 1);

    // frame counter wrap from 0xFFFF
    @(negedge clk);
    force dut_b.r_frame_cnt = 16'hFFFF;
    #1;
    release dut_b.r_frame_cnt;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (vga_b.startOfFrame) begin
        found = 1'b1;
        break;
      end
    end
    check("b_wrap_sof_seen", 32'(found), 1);
    check("b_wrap_frames", vga_b.frameCount, 0);
    check("b_wrap_x", vga_b.pixelX, 0);
    check("b_wrap_y", vga_b.pixelY, 0);

    // asynchronous reset in the middle of a line, inside hsync
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (vga_b.pixelX == 11 && vga_b.pixelY == 2) begin
        found = 1'b1;
        break;
      end
    end
    check("b_midline_reached", 32'(found), 1);
    check("b_hsync_before_reset", 32'(vga_b.hsync), 0);
    #2 resetN_b = 1'b0;
    #1;
    check("b_arst_x", vga_b.pixelX, 0);
    check("b_arst_y", vga_b.pixelY, 0);
    check("b_arst_tick", 32'(vga_b.pixelTick), 0);
    check("b_arst_visible", 32'(vga_b.visible), 0);
    check("b_arst_frames", vga_b.frameCount, 0);
    check("b_arst_hsync", 32'(vga_b.hsync), 1);
    check("b_arst_vsync", 32'(vga_b.vsync), 1);
    check("b_arst_blankN", 32'(vga_b.blankN), 0);
    @(negedge clk);
    resetN_b = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      check_scan("b_restart", n, cfg_b, vga_b.pixelTick, vga_b.pixelX, vga_b.pixelY,
                 vga_b.visible, vga_b.startOfFrame, vga_b.frameCount,
                 vga_b.hsync, vga_b.vsync, vga_b.blankN);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
